hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter REG_AW, default 5: register-number width.
REQ-002 Parameter NSRC, default 2: source operands checked per instruction.
REQ-003 Parameter NSTAGE, default 3: in-flight producer stages tracked (EXE, MEM, WB).
REQ-004 Parameter SELW, default $clog2(NSTAGE+1): forward-select width per operand.
REQ-005 Port CLK, input, 1: sole clock; all state updates on rising edge.
REQ-006 Port RESET, input, 1: asynchronous, active-low reset.
REQ-007 Port id_valid, input, 1: ID holds a real instruction.
REQ-008 Port id_src, input, NSRC*REG_AW: source register numbers, operand 0 in LSBs.
REQ-009 Port id_src_use, input, NSRC: operand is actually read (clear for immediates).
REQ-010 Port id_dst / id_wen / id_is_load, input, REG_AW/1/1: destination, writes-register flag, load flag.
REQ-011 Port id_is_branch, input, 1: instruction resolves in ID (branch or jr) and needs final operands there.
REQ-012 Port flush, input, 1: kill the ID instruction this cycle.
REQ-013 Port stall, output, 1: freeze PC and IF/ID; combinational.
REQ-014 Port fwd_sel, output, NSRC*SELW: registered per-operand select, valid while the consumer is in EXE; 0 = register file.
REQ-015 Port stall_count, output, 16: saturating count of stall cycles.

Function
REQ-016 Shadow pipe SHALL hold NSTAGE entries {valid, dst, wen, is_load}; entry 0 = EXE.
REQ-017 Each cycle SHALL shift entry i to i+1 and drop entry NSTAGE-1.
REQ-018 Entry 0 SHALL load ID fields when id_valid & !stall & !flush; otherwise a bubble (valid=0).
REQ-019 A producer SHALL be eligible when valid & wen & dst!=0 & dst==src & id_src_use[k].
REQ-020 Load-use stall SHALL assert when entry 0 is an eligible load for any operand.
REQ-021 Branch stall SHALL assert when id_is_branch and (entry 0 eligible, or entry 1 an eligible load).
REQ-022 stall SHALL be 0 whenever id_valid=0 or flush=1; flush wins over any stall cause.
REQ-023 When ID advances, fwd_sel[k] SHALL register j+1 for the youngest eligible entry j (entry 0 beats 1 beats 2); 0 if none.
REQ-024 With stall=1 or flush=1, fwd_sel SHALL register 0.
REQ-025 Register 0 SHALL never be forwarded or cause a stall.
REQ-026 Multi-cycle stalls SHALL release automatically as the producer advances; no internal timeout.
REQ-027 stall_count SHALL increment once per cycle with stall=1 and hold at 16'hFFFF.
REQ-028 Latency: stall 0 cycles (same cycle as ID inputs); fwd_sel 1 cycle.

Reset
REQ-029 RESET low SHALL asynchronously clear all shadow valid bits, fwd_sel and stall_count.
REQ-030 stall SHALL read 0 during reset.
REQ-031 Release SHALL be synchronous to CLK; the first edge after release accepts ID normally.
REQ-032 Reset mid-stall SHALL discard the stall; no producer state survives.

Structure
REQ-033 Shared package pipe_pkg SHALL hold REG_AW, the shadow-entry struct and the encoding FWD_RF=0.
REQ-034 Sub-module hazard_match SHALL compare one operand against all entries and return eligible mask, youngest index and load-hit flag; instantiated NSRC times.
REQ-035 RTL target: 120-400 lines, no latches, no multi-driven nets.

Verification
REQ-036 add r3 then add r4,r3,r5 back-to-back -> stall=0; next cycle fwd_sel[0]=1, fwd_sel[1]=0.
REQ-037 lw r2 then sub r6,r2,r7 -> stall=1 exactly 1 cycle, stall_count 0->1; after release fwd_sel[0]=2.
REQ-038 add r8 then beq r8,r0 -> stall=1 for 1 cycle; lw r8 then beq r8 -> 2 cycles stall; stall_count +3 total.
REQ-039 Write to r0 followed by reader of r0, and addi with id_src_use[1]=0 matching rt -> stall=0, fwd_sel=0.
REQ-040 Load-use stall with flush=1 in the same cycle -> stall=0, bubble into entry 0, fwd_sel=0 next cycle.
REQ-041 RESET low mid-stall, then release -> stall=0, fwd_sel=0, stall_count=0; 65536 forced stalls -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for hazard detection.
// Shadow-entry layout and forward-select encoding.
package pipe_pkg;

  localparam int REG_AW = 5;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              wen;
    logic              is_load;
  } shadow_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage hazard bundle between decode and the hazard unit.
// master = decode side, slave = hazard unit.
interface hazard_forward_unit_if #(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int SELW   = 2
);

  logic                   id_valid;
  logic [NSRC*REG_AW-1:0] id_src;
  logic [NSRC-1:0]        id_src_use;
  logic [REG_AW-1:0]      id_dst;
  logic                   id_wen;
  logic                   id_is_load;
  logic                   id_is_branch;
  logic                   flush;
  logic                   stall;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic [15:0]            stall_count;

  modport master (
    output id_valid, id_src, id_src_use,
    output id_dst, id_wen, id_is_load,
    output id_is_branch, flush,
    input  stall, fwd_sel, stall_count
  );

  modport slave (
    input  id_valid, id_src, id_src_use,
    input  id_dst, id_wen, id_is_load,
    input  id_is_branch, flush,
    output stall, fwd_sel, stall_count
  );

endinterface

// File: rtl/hazard_match.sv
// Compares one source operand against every shadow entry.
// Returns eligible mask, load-hit mask and youngest hit.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int IDXW   = 2
) (
  input  logic [REG_AW-1:0]       src,
  input  logic                    src_use,
  input  shadow_t [NSTAGE-1:0]    ents,
  output logic [NSTAGE-1:0]       elig,
  output logic [NSTAGE-1:0]       load_hit,
  output logic                    hit,
  output logic [IDXW-1:0]         young_idx
);

  // Scan oldest to youngest so the youngest hit wins
  always_comb begin
    elig      = '0;
    load_hit  = '0;
    hit       = 1'b0;
    young_idx = '0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      elig[j] = ents[j].valid & ents[j].wen
              & (ents[j].dst != '0)
              & (ents[j].dst == src)
              & src_use;
      load_hit[j] = elig[j] & ents[j].is_load;
      if (elig[j]) begin
        hit       = 1'b1;
        young_idx = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use / branch stall detection and forward select.
// Tracks in-flight producers in a shadow pipe.
module hazard_forward_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int NSRC   = 2,
  parameter int NSTAGE = 3,
  parameter int SELW   = $clog2(NSTAGE + 1)
) (
  input logic                 CLK,
  input logic                 RESET,
  hazard_forward_unit_if.slave h
);

  localparam int IDXW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  shadow_t [NSTAGE-1:0]  shadow_q, shadow_d;
  logic [NSRC*SELW-1:0]  fwd_sel_q, fwd_sel_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [NSTAGE-1:0]     elig     [NSRC];
  logic [NSTAGE-1:0]     load_hit [NSRC];
  logic [NSRC-1:0]       hit;
  logic [IDXW-1:0]       young    [NSRC];

  logic lu_haz, br_haz, stall, advance;

  for (genvar k = 0; k < NSRC; k++) begin : g_match
    hazard_match #(
      .NSTAGE (NSTAGE),
      .IDXW   (IDXW)
    ) u_match (
      .src       (h.id_src[k*REG_AW +: REG_AW]),
      .src_use   (h.id_src_use[k]),
      .ents      (shadow_q),
      .elig      (elig[k]),
      .load_hit  (load_hit[k]),
      .hit       (hit[k]),
      .young_idx (young[k])
    );
  end

  // Combine per-operand matches into stall causes
  always_comb begin
    lu_haz = 1'b0;
    br_haz = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      lu_haz = lu_haz | load_hit[k][0];
      br_haz = br_haz | elig[k][0] | load_hit[k][1];
    end
  end

  assign stall = RESET & h.id_valid & ~h.flush
               & (lu_haz | (h.id_is_branch & br_haz));
  assign advance = h.id_valid & ~stall & ~h.flush;

  // Shadow shift, forward select and stall counter
  always_comb begin
    shadow_d    = '0;
    fwd_sel_d   = '0;
    cnt_d       = cnt_q;
    if (advance) begin
      shadow_d[0].valid   = 1'b1;
      shadow_d[0].dst     = h.id_dst;
      shadow_d[0].wen     = h.id_wen;
      shadow_d[0].is_load = h.id_is_load;
    end
    for (int i = 1; i < NSTAGE; i++) begin
      shadow_d[i] = shadow_q[i-1];
    end
    for (int k = 0; k < NSRC; k++) begin
      fwd_sel_d[k*SELW +: SELW] = SELW'(FWD_RF);
      if (advance && hit[k]) begin
        fwd_sel_d[k*SELW +: SELW] = SELW'(young[k]) + SELW'(1);
      end
    end
    if (stall && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shadow_q  <= '0;
      fwd_sel_q <= '0;
      cnt_q     <= '0;
    end else begin
      shadow_q  <= shadow_d;
      fwd_sel_q <= fwd_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign h.stall       = stall;
  assign h.fwd_sel     = fwd_sel_q;
  assign h.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit.
// Hand-computed stall / forward / counter expectations.
module tb_hazard_forward_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hazard_forward_unit_if #(
    .REG_AW (5),
    .NSRC   (2),
    .SELW   (2)
  ) hif ();

  hazard_forward_unit u_dut (
    .CLK   (clk),
    .RESET (rst_n),
    .h     (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v,
                     input logic [4:0] s0,
                     input logic [4:0] s1,
                     input logic [1:0] use_m,
                     input logic [4:0] dst,
                     input logic wen,
                     input logic ld,
                     input logic br,
                     input logic fl);
    hif.id_valid     = v;
    hif.id_src       = {s1, s0};
    hif.id_src_use   = use_m;
    hif.id_dst       = dst;
    hif.id_wen       = wen;
    hif.id_is_load   = ld;
    hif.id_is_branch = br;
    hif.flush        = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(hif.stall), 0);
    chk("rst_fwd", 32'(hif.fwd_sel), 0);
    chk("rst_cnt", 32'(hif.stall_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // add r3 ; add r4,r3,r5
    drv(1, 1, 2, 2'b11, 3, 1, 0, 0, 0);
    tick();
    drv(1, 3, 5, 2'b11, 4, 1, 0, 0, 0);
    @(negedge clk);
    chk("alu_stall", 32'(hif.stall), 0);
    tick();
    chk("alu_fwd", 32'(hif.fwd_sel), 32'h1);
    drain();

    // lw r2 ; sub r6,r2,r7
    drv(1, 1, 0, 2'b01, 2, 1, 1, 0, 0);
    tick();
    drv(1, 2, 7, 2'b11, 6, 1, 0, 0, 0);
    @(negedge clk);
    chk("lu_stall", 32'(hif.stall), 1);
    chk("lu_cnt0", 32'(hif.stall_count), 0);
    tick();
    chk("lu_cnt1", 32'(hif.stall_count), 1);
    chk("lu_fwd_stall", 32'(hif.fwd_sel), 0);
    @(negedge clk);
    chk("lu_release", 32'(hif.stall), 0);
    tick();
    chk("lu_fwd", 32'(hif.fwd_sel), 32'h2);
    drain();

    // add r8 ; beq r8,r0
    drv(1, 1, 2, 2'b11, 8, 1, 0, 0, 0);
    tick();
    drv(1, 8, 0, 2'b11, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("br_alu_stall", 32'(hif.stall), 1);
    tick();
    @(negedge clk);
    chk("br_alu_rel", 32'(hif.stall), 0);
    tick();
    chk("br_alu_fwd", 32'(hif.fwd_sel), 32'h2);
    drain();

    // lw r8 ; beq r8,r0
    drv(1, 1, 0, 2'b01, 8, 1, 1, 0, 0);
    tick();
    drv(1, 8, 0, 2'b11, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("br_ld_st1", 32'(hif.stall), 1);
    tick();
    @(negedge clk);
    chk("br_ld_st2", 32'(hif.stall), 1);
    tick();
    @(negedge clk);
    chk("br_ld_rel", 32'(hif.stall), 0);
    tick();
    chk("br_ld_fwd", 32'(hif.fwd_sel), 32'h3);
    chk("br_cnt", 32'(hif.stall_count), 4);
    drain();

    // lw r0 ; reader of r0
    drv(1, 1, 0, 2'b01, 0, 1, 1, 0, 0);
    tick();
    drv(1, 0, 0, 2'b11, 5, 1, 0, 0, 0);
    @(negedge clk);
    chk("r0_stall", 32'(hif.stall), 0);
    tick();
    chk("r0_fwd", 32'(hif.fwd_sel), 0);
    drain();

    // lw r9 ; addi with rt=r9 unused
    drv(1, 1, 0, 2'b01, 9, 1, 1, 0, 0);
    tick();
    drv(1, 1, 9, 2'b01, 10, 1, 0, 0, 0);
    @(negedge clk);
    chk("imm_stall", 32'(hif.stall), 0);
    tick();
    chk("imm_fwd", 32'(hif.fwd_sel), 0);
    drain();

    // lw r2 ; sub r6,r2,r7 flushed
    drv(1, 1, 0, 2'b01, 2, 1, 1, 0, 0);
    tick();
    drv(1, 2, 7, 2'b11, 6, 1, 0, 0, 1);
    @(negedge clk);
    chk("fl_stall", 32'(hif.stall), 0);
    tick();
    chk("fl_fwd", 32'(hif.fwd_sel), 0);
    drv(1, 6, 2, 2'b11, 11, 1, 0, 0, 0);
    @(negedge clk);
    chk("fl_next_stall", 32'(hif.stall), 0);
    tick();
    chk("fl_bubble_fwd", 32'(hif.fwd_sel), 32'h8);
    chk("fl_cnt", 32'(hif.stall_count), 4);
    drain();

    // reset in the middle of a load-use stall
    drv(1, 1, 0, 2'b01, 2, 1, 1, 0, 0);
    tick();
    drv(1, 2, 7, 2'b11, 6, 1, 0, 0, 0);
    @(negedge clk);
    chk("mr_stall_pre", 32'(hif.stall), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_stall_rst", 32'(hif.stall), 0);
    chk("mr_cnt_rst", 32'(hif.stall_count), 0);
    chk("mr_fwd_rst", 32'(hif.fwd_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_stall_rel", 32'(hif.stall), 0);
    tick();
    chk("mr_fwd_rel", 32'(hif.fwd_sel), 0);
    chk("mr_cnt_rel", 32'(hif.stall_count), 0);
    drain();

    // 65536 forced stalls: lw r8 then two-cycle beq stall
    for (int i = 0; i < 32768; i++) begin
      drv(1, 0, 0, 2'b00, 8, 1, 1, 0, 0);
      tick();
      drv(1, 8, 0, 2'b01, 0, 0, 0, 1, 0);
      tick();
      tick();
      if (i == 15999) begin
        chk("sat_mid", 32'(hif.stall_count), 32000);
      end
    end
    chk("sat_cnt", 32'(hif.stall_count), 32'hFFFF);
    drain();
    chk("sat_hold", 32'(hif.stall_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
